// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - Hi/Lo scheduler op encodings, FSM states and shared widths
package hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } hiloStateT;

    // Without the divider, DIV/DIVU fall into the reserved space and are ignored.
    function automatic logic isReserved(input logic [2:0] op);
`ifdef HILO_DIV_EN
        return op[2] & op[1];
`else
        return (op[2] & op[1]) | (op[2:1] == 2'b01);
`endif
    endfunction

endpackage

// File: rtl/hilo_divider.sv
// rtl/hilo_divider.sv - iterative radix-2 restoring divider core (built only with HILO_DIV_EN)
`ifdef HILO_DIV_EN
module hilo_divider
    import hilo_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        iLoad,
    input  logic        iSigned,
    input  logic        iStep,
    input  logic [31:0] iDividend,
    input  logic [31:0] iDivisor,
    output logic [31:0] oQuotient,
    output logic [31:0] oRemainder
);

    logic [31:0] quo, rem, dsr;
    logic        negQuo, negRem;
    logic        dividendNeg, divisorNeg;
    logic [32:0] remShift, diff;
    logic [31:0] quoStep, remStep;

    assign dividendNeg = iSigned & iDividend[31];
    assign divisorNeg  = iSigned & iDivisor[31];

    // quo doubles as the dividend shift register; its MSB feeds the partial remainder.
    assign remShift = {rem, quo[31]};
    assign diff     = remShift - {1'b0, dsr};

    always_comb begin
        if (diff[32]) begin
            remStep = remShift[31:0];
            quoStep = {quo[30:0], 1'b0};
        end else begin
            remStep = diff[31:0];
            quoStep = {quo[30:0], 1'b1};
        end
    end

    // Outputs reflect the step in progress so the final edge can commit directly.
    assign oQuotient  = negQuo ? -quoStep : quoStep;
    assign oRemainder = negRem ? -remStep : remStep;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            quo    <= '0;
            rem    <= '0;
            dsr    <= '0;
            negQuo <= 1'b0;
            negRem <= 1'b0;
        end else if (iLoad) begin
            quo    <= dividendNeg ? -iDividend : iDividend;
            rem    <= '0;
            dsr    <= divisorNeg ? -iDivisor : iDivisor;
            negQuo <= dividendNeg ^ divisorNeg;
            negRem <= dividendNeg;
        end else if (iStep) begin
            quo <= quoStep;
            rem <= remStep;
        end
    end

endmodule
`endif

// File: rtl/hilo_scheduler.sv
// rtl/hilo_scheduler.sv - Hi/Lo owner and MULT/DIV/MTHI/MTLO sequencer; divider built with HILO_DIV_EN
module hilo_scheduler
    import hilo_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        iOpValid,
    input  logic [2:0]  iOp,
    input  logic [31:0] iRs,
    input  logic [31:0] iRt,
    input  logic        iReadReq,
    output logic        oStall,
    output logic        oBusy,
    output logic        oDone,
    output logic        oDivByZero,
    output logic [31:0] oHi,
    output logic [31:0] oLo
);

    hiloStateT        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [63:0]      prod, prodNext, product, opA, opB;
    logic [31:0]      hi, hiNext, lo, loNext;
    logic             done, doneNext, dbz, dbzNext;
    logic             opLegal, accept, mulSigned;

    assign opLegal = iOpValid & ~isReserved(iOp);
    assign accept  = opLegal & (state == IDLE);
    assign oBusy   = (state != IDLE);
    assign oStall  = oBusy & (iReadReq | opLegal);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
    assign mulSigned = (iOp == OP_MULT);
    assign opA       = {{32{mulSigned & iRs[31]}}, iRs};
    assign opB       = {{32{mulSigned & iRt[31]}}, iRt};
    assign product   = opA * opB;

`ifdef HILO_DIV_EN
    logic        divZero, divZeroNext, divLoad, divStep;
    logic [31:0] divQuo, divRem;

    hilo_divider uDivider (
        .Clk        (Clk),
        .Reset      (Reset),
        .iLoad      (divLoad),
        .iSigned    (iOp == OP_DIV),
        .iStep      (divStep),
        .iDividend  (iRs),
        .iDivisor   (iRt),
        .oQuotient  (divQuo),
        .oRemainder (divRem)
    );
`endif

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        prodNext  = prod;
        hiNext    = hi;
        loNext    = lo;
        doneNext  = 1'b0;
        dbzNext   = 1'b0;
`ifdef HILO_DIV_EN
        divZeroNext = divZero;
        divLoad     = 1'b0;
        divStep     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    case (iOp)
                        OP_MULT, OP_MULTU: begin
                            prodNext  = product;
                            cntNext   = CNT_W'(MUL_CYCLES - 1);
                            stateNext = MUL;
                        end
                        OP_MTHI: hiNext = iRs;
                        OP_MTLO: loNext = iRs;
`ifdef HILO_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            divLoad     = 1'b1;
                            divZeroNext = (iRt == 32'd0);
                            cntNext     = CNT_W'(DIV_STEPS - 1);
                            stateNext   = DIV;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt == '0) begin
                    {hiNext, loNext} = prod;
                    doneNext         = 1'b1;
                    stateNext        = IDLE;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
`ifdef HILO_DIV_EN
            DIV: begin
                divStep = 1'b1;
                if (divZero) begin
                    doneNext  = 1'b1;
                    dbzNext   = 1'b1;
                    stateNext = IDLE;
                end else if (cnt == '0) begin
                    hiNext    = divRem;
                    loNext    = divQuo;
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            prod  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            prod  <= prodNext;
            hi    <= hiNext;
            lo    <= loNext;
            done  <= doneNext;
            dbz   <= dbzNext;
        end
    end

`ifdef HILO_DIV_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) divZero <= 1'b0;
        else        divZero <= divZeroNext;
    end
`endif

    assign oDone      = done;
    assign oDivByZero = dbz;
    assign oHi        = hi;
    assign oLo        = lo;

endmodule

// File: tb/tb_hilo_scheduler.sv
// tb/tb_hilo_scheduler.sv - self-checking bench for hilo_scheduler against an arithmetic reference model
module tb_hilo_scheduler;

    localparam int MULC = 4;
`ifdef HILO_DIV_EN
    localparam bit DIVEN = 1'b1;
`else
    localparam bit DIVEN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        iOpValid = 1'b0;
    logic [2:0]  iOp = 3'b000;
    logic [31:0] iRs = '0;
    logic [31:0] iRt = '0;
    logic        iReadReq = 1'b0;
    logic        oStall, oBusy, oDone, oDivByZero;
    logic [31:0] oHi, oLo;

    int total = 0;
    int passed = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;

    hilo_scheduler #(.MUL_CYCLES(MULC)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .iOpValid   (iOpValid),
        .iOp        (iOp),
        .iRs        (iRs),
        .iRt        (iRt),
        .iReadReq   (iReadReq),
        .oStall     (oStall),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oDivByZero (oDivByZero),
        .oHi        (oHi),
        .oLo        (oLo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] refMul(input logic signedOp, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (signedOp) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    // Returns {hi, lo}: remainder and quotient with truncating division semantics.
    function automatic logic [63:0] refDiv(input logic signedOp, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (signedOp) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int          expBusy, n, early;
        logic        expDone, expDbz;
        logic [63:0] r;
        expBusy = 0;
        expDone = 1'b0;
        expDbz  = 1'b0;
        case (op)
            3'b000, 3'b001: begin
                r = refMul(op == 3'b000, rs, rt);
                {modelHi, modelLo} = r;
                expBusy = MULC;
                expDone = 1'b1;
            end
            3'b010, 3'b011: begin
                if (DIVEN) begin
                    expDone = 1'b1;
                    if (rt == 32'd0) begin
                        expBusy = 1;
                        expDbz  = 1'b1;
                    end else begin
                        r = refDiv(op == 3'b010, rs, rt);
                        {modelHi, modelLo} = r;
                        expBusy = 32;
                    end
                end
            end
            3'b100: modelHi = rs;
            3'b101: modelLo = rs;
            default: ;
        endcase
        @(negedge Clk);
        iOpValid = 1'b1;
        iOp = op;
        iRs = rs;
        iRt = rt;
        @(negedge Clk);
        iOpValid = 1'b0;
        n = 0;
        early = 0;
        while (oBusy === 1'b1 && n < 100) begin
            if (oDone === 1'b1) early++;
            n++;
            @(negedge Clk);
        end
        check({tag, " busy cycles"}, 64'(n), 64'(expBusy));
        check({tag, " early done"}, 64'(early), 64'd0);
        check({tag, " done"}, 64'(oDone), 64'(expDone));
        check({tag, " divbyzero"}, 64'(oDivByZero), 64'(expDbz));
        check({tag, " hi"}, 64'(oHi), 64'(modelHi));
        check({tag, " lo"}, 64'(oLo), 64'(modelLo));
        @(negedge Clk);
        check({tag, " done pulse width"}, 64'({oDone, oDivByZero}), 64'd0);
    endtask

    initial begin
        int n, stalls;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        // Reset state with a read request asserted
        iReadReq = 1'b1;
        #12;
        check("reset busy", 64'(oBusy), 64'd0);
        check("reset outs", 64'({oDone, oDivByZero, oStall}), 64'd0);
        check("reset hilo", {oHi, oLo}, 64'd0);
        iReadReq = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;

        runOp("mult neg", 3'b000, 32'hFFFFFFFD, 32'd7);
        check("mult const", {oHi, oLo}, 64'hFFFFFFFF_FFFFFFEB);
        runOp("multu big", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp("mthi", 3'b100, 32'h0000_1234, 32'd0);
        runOp("mtlo", 3'b101, 32'hCAFE_F00D, 32'd0);

        runOp("divu 100/7", 3'b011, 32'd100, 32'd7);
        runOp("div -7/2", 3'b010, 32'hFFFFFFF9, 32'd2);
        if (DIVEN) check("div -7/2 const", {oHi, oLo}, 64'hFFFFFFFF_FFFFFFFD);
        runOp("mthi pre", 3'b100, 32'h0000_1234, 32'd0);
        runOp("div by 0", 3'b010, 32'h1111_2222, 32'd0);
        check("div by 0 hi kept", 64'(oHi), 64'h1234);
        runOp("div min/-1", 3'b010, 32'h80000000, 32'hFFFFFFFF);
        runOp("divu by 0", 3'b011, 32'd5, 32'd0);

        // Reserved op in idle: no stall, no state change
        @(negedge Clk);
        iOpValid = 1'b1;
        iOp = 3'b110;
        iRs = 32'hDEAD_BEEF;
        #1;
        check("reserved idle stall", 64'(oStall), 64'd0);
        @(negedge Clk);
        iOpValid = 1'b0;
        check("reserved idle busy", 64'(oBusy), 64'd0);
        check("reserved idle hilo", {oHi, oLo}, {modelHi, modelLo});

        // Stall sequence: MULT busy, reserved op does not stall, then read + second op stall
        {modelHi, modelLo} = refMul(1'b1, 32'h0001_0003, 32'hFFFF_0005);
        @(negedge Clk);
        iOpValid = 1'b1;
        iOp = 3'b000;
        iRs = 32'h0001_0003;
        iRt = 32'hFFFF_0005;
        @(negedge Clk);
        iOp = 3'b111;
        #1;
        check("reserved busy stall", 64'(oStall), 64'd0);
        @(negedge Clk);
        iOp = 3'b001;
        iRs = 32'h8000_0001;
        iRt = 32'h0000_0003;
        iReadReq = 1'b1;
        #1;
        n = 0;
        stalls = 0;
        while (oBusy === 1'b1 && n < 100) begin
            if (oStall === 1'b1) stalls++;
            n++;
            @(negedge Clk);
            #1;
        end
        check("stall busy cycles", 64'(n), 64'(MULC - 1));
        check("stall cycles", 64'(stalls), 64'(MULC - 1));
        check("stall after commit", 64'(oStall), 64'd0);
        check("first mult done", 64'(oDone), 64'd1);
        check("first mult hilo", {oHi, oLo}, {modelHi, modelLo});
        @(negedge Clk);
        iOpValid = 1'b0;
        iReadReq = 1'b0;
        check("second mult zero gap", 64'(oBusy), 64'd1);
        {modelHi, modelLo} = refMul(1'b0, 32'h8000_0001, 32'h0000_0003);
        n = 0;
        while (oBusy === 1'b1 && n < 100) begin
            n++;
            @(negedge Clk);
        end
        check("second mult busy", 64'(n), 64'(MULC));
        check("second mult hilo", {oHi, oLo}, {modelHi, modelLo});

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                default: ;
            endcase
            runOp("random", rop, ra, rb);
        end

        // Asynchronous reset in the middle of a long operation
        runOp("pre reset", 3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge Clk);
        iOpValid = 1'b1;
        iOp = DIVEN ? 3'b010 : 3'b000;
        iRs = 32'h7654_3210;
        iRt = 32'd3;
        @(negedge Clk);
        iOpValid = 1'b0;
        repeat (DIVEN ? 9 : 2) @(negedge Clk);
        #2;
        Reset = 1'b0;
        modelHi = '0;
        modelLo = '0;
        #1;
        check("async reset busy", 64'(oBusy), 64'd0);
        check("async reset hilo", {oHi, oLo}, 64'd0);
        check("async reset done", 64'(oDone), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        check("reset held no done", 64'(oDone), 64'd0);
        runOp("mtlo after reset", 3'b101, 32'h55, 32'd0);
        check("mtlo after reset const", {oHi, oLo}, 64'h55);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hilo_scheduler.md
# hilo_scheduler

Owns the Hi/Lo register pair and sequences all multi-cycle MULT/MULTU/DIV/DIVU work plus MTHI/MTLO writes for the pipelined MIPS core. Sits beside the EX stage; its oHi/oLo feed the ID stage Hi/Lo inputs. It stalls ID whenever an instruction needs Hi/Lo, or a new Hi/Lo operation arrives, while an operation is still in flight.

## Interface
- MUL_CYCLES, 4, cycles from multiply accept to Hi/Lo commit; legal 1..15.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- iOpValid  in  1  Hi/Lo operation offered this cycle; held by requester until accepted.
- iOp  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
- iRs  in  32  rs operand (dividend/multiplicand; MTHI/MTLO source).
- iRt  in  32  rt operand (divisor/multiplier).
- iReadReq  in  1  ID holds MFHI/MFLO needing current Hi/Lo.
- oStall  out  1  combinational; stall ID/IF and hold offered op.
- oBusy  out  1  registered; operation in flight.
- oDone  out  1  registered one-cycle pulse on mult/div commit.
- oDivByZero  out  1  registered one-cycle pulse, with oDone, on divide by zero.
- oHi, oLo  out  32 each  architectural Hi/Lo.

## Operation
- States: IDLE, MUL, DIV. Reset (Reset=0) forces IDLE, counter 0, Hi=Lo=0, oBusy=oDone=oDivByZero=0, abandons any op asynchronously.
- Accept: iOpValid & iOp not reserved & state IDLE at a rising edge. Reserved codes ignored, never stall.
- oStall = oBusy & (iReadReq | (iOpValid & iOp not reserved)). No bypass of in-flight results.
- MTHI/MTLO (idle): Hi or Lo ← iRs at accept edge; state stays IDLE; no oDone.
- MULT/MULTU: 64-bit signed/unsigned product latched at accept; IDLE→MUL; counter = MUL_CYCLES−1, decrements each edge; at counter 0 edge, {Hi,Lo} ← product, oDone pulses, →IDLE.
- DIV/DIVU: radix-2 restoring divider on magnitudes (signed ops take absolute values at accept, remember signs). IDLE→DIV; 32 iteration edges, the 32nd also commits: Lo ← quotient, Hi ← remainder; signed fix-up: quotient negated if signs differ, remainder takes dividend sign. oDone pulses, →IDLE.
- Divisor 0: DIV entered for one cycle, next edge →IDLE, Hi/Lo unchanged, oDone and oDivByZero pulse.
- Arithmetic modulo 2^32 per half; −2^31 / −1 yields Lo=0x80000000, Hi=0.

## Timing
- Accept edge = edge 0. oBusy high from edge 0 until the commit edge; Hi/Lo valid the cycle after commit.
- Multiply: commit at edge MUL_CYCLES; oBusy high MUL_CYCLES cycles.
- Divide: commit at edge 32; oBusy high 32 cycles. Divide by zero: commit at edge 1.
- Op offered in the final busy cycle stalls; accepted at the first edge with oBusy=0 (back-to-back gap of zero idle cycles after busy falls).
- oDone/oDivByZero high exactly the cycle after commit edge.

## Configuration
- HILO_DIV_EN defined: divider, DIV state and oDivByZero behave as above.
- Undefined: divider logic omitted; DIV/DIVU treated as reserved (ignored, no stall, Hi/Lo unchanged, no oDone); oDivByZero tied 0.

## Structure
- Package hilo_pkg: op encodings, state enum, DIV_STEPS=32, counter width.
- One sub-module natural: hilo_divider (iterative restoring core: load, step, quotient/remainder, sign fix-up); hilo_scheduler holds FSM, stall logic, multiplier register, Hi/Lo.

## Test plan
- MULT iRs=0xFFFFFFFD, iRt=7, MUL_CYCLES=4 -> oBusy 4 cycles, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, single oDone pulse.
- DIVU 100/7 -> commit edge 32, Lo=14, Hi=2.
- DIV 0xFFFFFFF9 (−7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- MTHI 0x1234 then DIV x/0 -> Hi=0x1234 kept, Lo unchanged, oDone & oDivByZero at edge 1.
- iReadReq held during MULT busy plus second MULT offered -> oStall high every busy cycle, low after commit; second MULT accepted at first non-busy edge.
- Reset low at DIV iteration 10 -> oBusy, Hi, Lo = 0 immediately, no oDone; after release MTLO 0x55 -> Lo=0x55 next edge.
